sdft_bin_update: RTL and testbench

Sliding-DFT bin update sequencer for the SDFT datapath. Accepts one signed 8-bit sample at a time and keeps the last N samples in a circular delay line. For every bin it drives the operands of the downstream `complex_mult` stage, then writes each product back into its bin register. It sits between the sample source and `complex_mult`, owns all bin state, and exposes a read port for display/readout logic.

---
 rtl/sdft_pkg.sv | 39 +++
 rtl/sdft_delay_line.sv | 37 +++
 rtl/sdft_bin_update.sv | 139 +++++++++++++
 tb/tb_sdft_bin_update.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdft_pkg.sv
// sdft_pkg: shared definitions for the sliding-DFT bin update block.
//   - default geometry (bins, address width, twiddle fraction bits)
//   - sample / delta / bin / product widths
//   - FSM state enum
//   - twiddle table (real, imag) indexed by bin k, unity = 64
//   - sat8 clamp helper
package sdft_pkg;

   localparam int unsigned N_DEF       = 8;
   localparam int unsigned ADDR_W_DEF  = 3;
   localparam int unsigned TW_FRAC_DEF = 6;

   localparam int unsigned SAMPLE_W = 8;
   localparam int unsigned DELTA_W  = 9;
   localparam int unsigned BIN_W    = 8;
   localparam int unsigned PROD_W   = 16;

   typedef enum logic [1:0] {StIdle, StDelta, StBin, StDone} state_e;

   // round(64*cos(2*pi*k/8)), round(64*sin(2*pi*k/8)); table is built for 8 bins.
   localparam logic signed [7:0] TW_RE [8] = '{
      8'sd64, 8'sd45, 8'sd0, -8'sd45, -8'sd64, -8'sd45, 8'sd0, 8'sd45
   };
   localparam logic signed [7:0] TW_IM [8] = '{
      8'sd0, 8'sd45, 8'sd64, 8'sd45, 8'sd0, -8'sd45, -8'sd64, -8'sd45
   };

   // Clamp a signed 16-bit value to [-128, 127].
   function automatic logic signed [7:0] sat8(input logic signed [15:0] v);
      if (v > 16'sd127) begin
         return 8'sd127;
      end
      if (v < -16'sd128) begin
         return 8'sh80;
      end
      return v[7:0];
   endfunction

endpackage

// File: rtl/sdft_delay_line.sv
// sdft_delay_line: N-entry circular buffer of signed samples.
//   clk, reset : clock, synchronous active-low reset (clears entries and pointer)
//   wr_en      : write strobe; stores wr_data at the pointer and advances it mod N
//   wr_data    : sample to store
//   oldest     : entry at the write pointer, i.e. the sample from N writes ago
module sdft_delay_line
   import sdft_pkg::*;
#(
   parameter int unsigned N      = N_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic signed [SAMPLE_W-1:0] wr_data,
   output logic signed [SAMPLE_W-1:0] oldest
);

   logic signed [SAMPLE_W-1:0] mem_q [N];
   logic [ADDR_W-1:0]          ptr_q;

   assign oldest = mem_q[ptr_q];

   // N is a power of two, so the pointer wraps naturally.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < int'(N); i++) begin
            mem_q[i] <= '0;
         end
         ptr_q <= '0;
      end else if (wr_en) begin
         mem_q[ptr_q] <= wr_data;
         ptr_q        <= ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/sdft_bin_update.sv
// sdft_bin_update: sliding-DFT bin update sequencer.
//   clk, reset             : clock, synchronous active-low reset
//   sample_in/sample_valid : signed input sample, accepted when ready
//   ready                  : high in IDLE only
//   a_real/a_imag          : operand A to complex_mult = bin[k] + delta (real part saturated)
//   b_real/b_imag          : operand B to complex_mult = twiddle[k]
//   mult_real/mult_imag    : product from complex_mult, written back >>> TW_FRAC
//   busy                   : high outside IDLE
//   frame_done             : one-cycle pulse after the last bin is written
//   rd_addr/rd_real/rd_imag: combinational bin readout
module sdft_bin_update
   import sdft_pkg::*;
#(
   parameter int unsigned N       = N_DEF,
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned TW_FRAC = TW_FRAC_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   input  logic                       sample_valid,
   output logic                       ready,
   output logic signed [SAMPLE_W-1:0] a_real,
   output logic signed [SAMPLE_W-1:0] a_imag,
   output logic signed [SAMPLE_W-1:0] b_real,
   output logic signed [SAMPLE_W-1:0] b_imag,
   input  logic signed [PROD_W-1:0]   mult_real,
   input  logic signed [PROD_W-1:0]   mult_imag,
   output logic                       busy,
   output logic                       frame_done,
   input  logic [ADDR_W-1:0]          rd_addr,
   output logic signed [BIN_W-1:0]    rd_real,
   output logic signed [BIN_W-1:0]    rd_imag
);

   state_e state_q, state_d;

   logic signed [SAMPLE_W-1:0] sample_q;
   logic signed [DELTA_W-1:0]  delta_q;
   logic [ADDR_W-1:0]          k_q;
   logic signed [BIN_W-1:0]    bin_re_q [N];
   logic signed [BIN_W-1:0]    bin_im_q [N];

   logic signed [SAMPLE_W-1:0] oldest;
   logic                       dl_wr;
   logic                       last_bin;
   logic signed [15:0]         sum_re;

   assign dl_wr    = (state_q == StDelta);
   assign last_bin = (k_q == ADDR_W'(N - 1));

   // Wide enough that bin + delta never wraps before saturation.
   assign sum_re = {{8{bin_re_q[k_q][7]}}, bin_re_q[k_q]} + {{7{delta_q[8]}}, delta_q};

   assign rd_real = bin_re_q[rd_addr];
   assign rd_imag = bin_im_q[rd_addr];

   sdft_delay_line #(
      .N      (N),
      .ADDR_W (ADDR_W)
   ) u_delay_line (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (dl_wr),
      .wr_data (sample_q),
      .oldest  (oldest)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (sample_valid) state_d = StDelta;
         StDelta: state_d = StBin;
         StBin:   if (last_bin) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ready      = 1'b0;
      busy       = 1'b1;
      frame_done = 1'b0;
      a_real     = '0;
      a_imag     = '0;
      b_real     = '0;
      b_imag     = '0;
      unique case (state_q)
         StIdle: begin
            ready = 1'b1;
            busy  = 1'b0;
         end
         StDelta: ;
         StBin: begin
            a_real = sat8(sum_re);
            a_imag = bin_im_q[k_q];
            b_real = TW_RE[k_q];
            b_imag = TW_IM[k_q];
         end
         StDone: frame_done = 1'b1;
         default: ;
      endcase
   end

   // The sample is captured at accept so the source may change it right after.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sample_q <= '0;
         delta_q  <= '0;
         k_q      <= '0;
         for (int i = 0; i < int'(N); i++) begin
            bin_re_q[i] <= '0;
            bin_im_q[i] <= '0;
         end
      end else begin
         if (state_q == StIdle && sample_valid) begin
            sample_q <= sample_in;
         end
         if (state_q == StDelta) begin
            delta_q <= {sample_q[7], sample_q} - {oldest[7], oldest};
            k_q     <= '0;
         end
         if (state_q == StBin) begin
            bin_re_q[k_q] <= sat8(mult_real >>> TW_FRAC);
            bin_im_q[k_q] <= sat8(mult_imag >>> TW_FRAC);
            k_q           <= k_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sdft_bin_update.sv
module tb_sdft_bin_update;

   localparam int N = 8;

   logic              clk;
   logic              reset;
   logic signed [7:0] sample_in;
   logic              sample_valid;
   logic              ready;
   logic signed [7:0] a_real, a_imag, b_real, b_imag;
   logic signed [15:0] mult_real, mult_imag;
   logic              busy;
   logic              frame_done;
   logic [2:0]        rd_addr;
   logic signed [7:0] rd_real, rd_imag;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   int tw_re [N];
   int tw_im [N];
   int ref_re [N];
   int ref_im [N];
   int dl [N];
   int ptr;
   int exp_ar [N];
   int exp_ai [N];
   int seen_ar0;

   localparam int ONE_RE [N] = '{10, 7, 0, -8, -10, -8, 0, 7};
   localparam int ONE_IM [N] = '{0, 7, 10, 7, 0, -8, -10, -8};

   sdft_bin_update dut (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .ready        (ready),
      .a_real       (a_real),
      .a_imag       (a_imag),
      .b_real       (b_real),
      .b_imag       (b_imag),
      .mult_real    (mult_real),
      .mult_imag    (mult_imag),
      .busy         (busy),
      .frame_done   (frame_done),
      .rd_addr      (rd_addr),
      .rd_real      (rd_real),
      .rd_imag      (rd_imag)
   );

   // complex_mult stand-in
   always_comb begin
      mult_real = 16'(int'(a_real) * int'(b_real) - int'(a_imag) * int'(b_imag));
      mult_imag = 16'(int'(a_real) * int'(b_imag) + int'(a_imag) * int'(b_real));
   end

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   function automatic int sat(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         ref_re[i] = 0;
         ref_im[i] = 0;
         dl[i]     = 0;
      end
      ptr = 0;
   endtask

   // One sliding-DFT step: X[k] <- (X[k] + x_new - x_old) * W^k, floored to integer.
   task automatic model_apply(input int s);
      int delta, pr, pi;
      delta   = s - dl[ptr];
      dl[ptr] = s;
      ptr     = (ptr + 1) % N;
      for (int k = 0; k < N; k++) begin
         exp_ar[k] = sat(ref_re[k] + delta);
         exp_ai[k] = ref_im[k];
         pr = exp_ar[k] * tw_re[k] - exp_ai[k] * tw_im[k];
         pi = exp_ar[k] * tw_im[k] + exp_ai[k] * tw_re[k];
         ref_re[k] = sat(pr >>> 6);
         ref_im[k] = sat(pi >>> 6);
      end
   endtask

   task automatic apply_reset();
      sample_valid = 1'b0;
      reset        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      model_clear();
   endtask

   // Drives one sample from IDLE and checks operands and timing of the whole frame.
   task automatic run_frame(input logic signed [7:0] s);
      n_checks++;
      if (ready !== 1'b1) $display("FAIL frame_ready_before: got %b want 1", ready);
      else n_pass++;
      model_apply(int'(s));
      sample_in    = s;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      sample_in    = 8'($urandom());
      n_checks++;
      if (busy !== 1'b1 || ready !== 1'b0 || {a_real, b_real} !== 16'h0)
         $display("FAIL delta_cycle: got busy=%b ready=%b a=%0d b=%0d want 1 0 0 0",
                  busy, ready, a_real, b_real);
      else n_pass++;
      for (int c = 1; c <= N + 2; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) seen_ar0 = int'(a_real);
         if (c <= N) begin
            n_checks++;
            if ({a_real, a_imag, b_real, b_imag} !== {8'(exp_ar[c-1]), 8'(exp_ai[c-1]),
                                                     8'(tw_re[c-1]), 8'(tw_im[c-1])})
               $display("FAIL operands k=%0d: got a=(%0d,%0d) b=(%0d,%0d) want a=(%0d,%0d) b=(%0d,%0d)",
                        c - 1, a_real, a_imag, b_real, b_imag,
                        exp_ar[c-1], exp_ai[c-1], tw_re[c-1], tw_im[c-1]);
            else n_pass++;
         end
         n_checks++;
         if (frame_done !== (c == N + 1))
            $display("FAIL frame_done_timing c=%0d: got %b want %b", c, frame_done, c == N + 1);
         else n_pass++;
      end
      n_checks++;
      if (ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL frame_ready_after: got ready=%b busy=%b want 1 0", ready, busy);
      else n_pass++;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0 || frame_done !== 1'b0)
         $display("FAIL reset_busy_done: got %b %b want 0 0", busy, frame_done);
      else n_pass++;
      n_checks++;
      if ({a_real, a_imag, b_real, b_imag} !== 32'h0)
         $display("FAIL reset_operands: got %h want 0", {a_real, a_imag, b_real, b_imag});
      else n_pass++;
      for (int i = 0; i < N; i++) begin
         rd_addr = 3'(i);
         #1;
         n_checks++;
         if ({rd_real, rd_imag} !== 16'h0)
            $display("FAIL reset_bin%0d: got (%0d,%0d) want (0,0)", i, rd_real, rd_imag);
         else n_pass++;
      end
   endtask

   task automatic test_single_sample();
      run_frame(8'sd10);
      for (int i = 0; i < N; i++) begin
         rd_addr = 3'(i);
         #1;
         n_checks++;
         if ({rd_real, rd_imag} !== {8'(ONE_RE[i]), 8'(ONE_IM[i])})
            $display("FAIL single_bin%0d: got (%0d,%0d) want (%0d,%0d)",
                     i, rd_real, rd_imag, ONE_RE[i], ONE_IM[i]);
         else n_pass++;
      end
   endtask

   task automatic test_accumulate();
      run_frame(8'sd10);
      n_checks++;
      if (seen_ar0 != 20) $display("FAIL accum_a0: got %0d want 20", seen_ar0);
      else n_pass++;
      rd_addr = 3'd0;
      #1;
      n_checks++;
      if ({rd_real, rd_imag} !== {8'sd20, 8'sd0})
         $display("FAIL accum_bin0: got (%0d,%0d) want (20,0)", rd_real, rd_imag);
      else n_pass++;
      // Samples 9 and 10 see their own value as the oldest entry (delta 0).
      for (int j = 0; j < 8; j++) run_frame(8'sd10);
      for (int i = 0; i < N; i++) begin
         rd_addr = 3'(i);
         #1;
         n_checks++;
         if ({rd_real, rd_imag} !== {8'(ref_re[i]), 8'(ref_im[i])})
            $display("FAIL accum_bin%0d: got (%0d,%0d) want (%0d,%0d)",
                     i, rd_real, rd_imag, ref_re[i], ref_im[i]);
         else n_pass++;
      end
   endtask

   task automatic test_saturation();
      apply_reset();
      run_frame(8'sd127);
      run_frame(8'sd127);
      n_checks++;
      if (seen_ar0 != 127) $display("FAIL sat_a0: got %0d want 127", seen_ar0);
      else n_pass++;
      rd_addr = 3'd0;
      #1;
      n_checks++;
      if ({rd_real, rd_imag} !== {8'sd127, 8'sd0})
         $display("FAIL sat_bin0: got (%0d,%0d) want (127,0)", rd_real, rd_imag);
      else n_pass++;
   endtask

   task automatic test_random();
      apply_reset();
      for (int f = 0; f < 12; f++) begin
         run_frame(8'($urandom()));
         for (int i = 0; i < N; i++) begin
            rd_addr = 3'(i);
            #1;
            n_checks++;
            if ({rd_real, rd_imag} !== {8'(ref_re[i]), 8'(ref_im[i])})
               $display("FAIL random_f%0d_bin%0d: got (%0d,%0d) want (%0d,%0d)",
                        f, i, rd_real, rd_imag, ref_re[i], ref_im[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_handshake();
      int prev_acc;
      int accepts;
      logic was_ready;
      prev_acc     = -1;
      accepts      = 0;
      sample_in    = 8'($urandom());
      sample_valid = 1'b1;
      for (int c = 0; c < 3 * (N + 3) - 1; c++) begin
         was_ready = ready;
         @(posedge clk);
         #1;
         if (was_ready) begin
            model_apply(int'(sample_in));
            if (prev_acc >= 0) begin
               n_checks++;
               if (c - prev_acc != N + 3)
                  $display("FAIL handshake_spacing: got %0d want %0d", c - prev_acc, N + 3);
               else n_pass++;
            end
            prev_acc  = c;
            accepts++;
            sample_in = 8'($urandom());
         end
      end
      sample_valid = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (accepts != 3) $display("FAIL handshake_accepts: got %0d want 3", accepts);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL handshake_idle: got busy=%b want 0", busy);
      else n_pass++;
      for (int i = 0; i < N; i++) begin
         rd_addr = 3'(i);
         #1;
         n_checks++;
         if ({rd_real, rd_imag} !== {8'(ref_re[i]), 8'(ref_im[i])})
            $display("FAIL handshake_bin%0d: got (%0d,%0d) want (%0d,%0d)",
                     i, rd_real, rd_imag, ref_re[i], ref_im[i]);
         else n_pass++;
      end
   endtask

   task automatic test_ignored_pulse();
      logic signed [7:0] s;
      s = 8'($urandom());
      model_apply(int'(s));
      sample_in    = s;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      // In BIN now; this one-cycle pulse must be dropped.
      sample_in    = 8'sd99;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      repeat (N + 4) @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0 || ready !== 1'b1)
         $display("FAIL ignored_idle: got busy=%b ready=%b want 0 1", busy, ready);
      else n_pass++;
      for (int i = 0; i < N; i++) begin
         rd_addr = 3'(i);
         #1;
         n_checks++;
         if ({rd_real, rd_imag} !== {8'(ref_re[i]), 8'(ref_im[i])})
            $display("FAIL ignored_bin%0d: got (%0d,%0d) want (%0d,%0d)",
                     i, rd_real, rd_imag, ref_re[i], ref_im[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_bin();
      sample_in    = 8'sd77;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (b_real !== 8'sh D3) $display("FAIL midbin_k3: got b_real=%0d want -45", b_real);
      else n_pass++;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_clear();
      n_checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0)
         $display("FAIL midbin_state: got ready=%b busy=%b done=%b want 1 0 0",
                  ready, busy, frame_done);
      else n_pass++;
      for (int i = 0; i < N; i++) begin
         rd_addr = 3'(i);
         #1;
         n_checks++;
         if ({rd_real, rd_imag} !== 16'h0)
            $display("FAIL midbin_bin%0d: got (%0d,%0d) want (0,0)", i, rd_real, rd_imag);
         else n_pass++;
      end
      // Delay line and pointer must also be clear: next frame behaves as from reset.
      run_frame(8'sd10);
      for (int i = 0; i < N; i++) begin
         rd_addr = 3'(i);
         #1;
         n_checks++;
         if ({rd_real, rd_imag} !== {8'(ONE_RE[i]), 8'(ONE_IM[i])})
            $display("FAIL midbin_after_bin%0d: got (%0d,%0d) want (%0d,%0d)",
                     i, rd_real, rd_imag, ONE_RE[i], ONE_IM[i]);
         else n_pass++;
      end
   endtask

   initial begin
      reset        = 1'b0;
      sample_in    = '0;
      sample_valid = 1'b0;
      rd_addr      = '0;
      seen_ar0     = 0;
      for (int k = 0; k < N; k++) begin
         tw_re[k] = $rtoi($floor(64.0 * $cos(2.0 * 3.14159265358979 * k / N) + 0.5));
         tw_im[k] = $rtoi($floor(64.0 * $sin(2.0 * 3.14159265358979 * k / N) + 0.5));
      end
      model_clear();

      test_reset();
      test_single_sample();
      test_accumulate();
      test_saturation();
      test_random();
      test_handshake();
      test_ignored_pulse();
      test_reset_mid_bin();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
